// File: rtl/stream_pkg.sv
// stream_pkg: shared FSM states, pattern mode encodings and default LFSR taps
package stream_pkg;
    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
    localparam logic [1:0] MODE_CNT = 2'd0, MODE_LFSR = 2'd1, MODE_WALK = 2'd2;
    localparam logic [31:0] DEF_LFSR_TAPS = 32'h8020_0003;
endpackage

// File: rtl/stream_src_gen_if.sv
// stream_src_gen_if: valid/ready stream bundle with source and sink views
interface stream_src_gen_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] data;
    logic valid;
    logic ready;
    modport master(output data, valid, input ready);
    modport slave(input data, valid, output ready);
endinterface

// File: rtl/stream_pattern_gen.sv
// stream_pattern_gen: counter / Galois LFSR / walking-one pattern register
module stream_pattern_gen import stream_pkg::*; #(
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEF_LFSR_TAPS),
    parameter logic [DATA_W-1:0] SEED = DATA_W'(1)
) (
    input  logic clk, rst, load, advance,
    input  logic [DATA_W-1:0] seed,
    input  logic [1:0] mode,
    output logic [DATA_W-1:0] value, nxt
);
    logic [DATA_W-1:0] step;
    // walking-one always restarts at bit 0; an all-zero LFSR seed would lock up
    always_comb begin
        step = mode == MODE_LFSR ? (value >> 1) ^ (value[0] ? LFSR_TAPS : '0) :
               mode == MODE_WALK ? (value << 1) | (value >> (DATA_W - 1)) : value + DATA_W'(1);
        nxt = load ? ((mode == MODE_WALK || (mode == MODE_LFSR && seed == '0)) ? DATA_W'(1) : seed) :
              advance ? step : value;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= SEED;
        else value <= nxt;
    end
endmodule

// File: rtl/stream_src_gen.sv
// stream_src_gen: bursty valid/ready pattern source with idle gaps between bursts
module stream_src_gen import stream_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int BURST_LEN = 8,
    parameter int GAP_LEN = 8,
    parameter logic [DATA_W-1:0] SEED = DATA_W'(1),
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(DEF_LFSR_TAPS),
    parameter int CNT_W = 32
) (
    input  logic clk, rst, en,
    input  logic [1:0] mode,
    stream_src_gen_if.master s,
    output logic [CNT_W-1:0] beat_cnt,
    output logic busy
);
    localparam int IW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
    localparam int GW = GAP_LEN > 1 ? $clog2(GAP_LEN) : 1;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [GW-1:0] gap, gap_n;
    logic valid_n, load, acc;
    logic [1:0] mode_q, pat_mode;
    logic [DATA_W-1:0] pat_val, pat_nxt;

    assign acc = s.valid && s.ready;
    assign pat_mode = state == IDLE ? mode : mode_q;

    stream_pattern_gen #(.DATA_W(DATA_W), .LFSR_TAPS(LFSR_TAPS), .SEED(SEED)) u_pat (
        .clk(clk), .rst(rst), .load(load), .advance(acc), .seed(SEED),
        .mode(pat_mode), .value(pat_val), .nxt(pat_nxt)
    );

    always_comb begin
        state_n = state;
        idx_n = idx;
        gap_n = gap;
        valid_n = s.valid;
        load = 1'b0;
        case (state)
            IDLE: if (en) begin
                state_n = BURST;
                valid_n = 1'b1;
                idx_n = '0;
                load = 1'b1;
            end
            BURST: if (acc) begin
                if (idx == IW'(BURST_LEN - 1) && GAP_LEN > 0) begin
                    state_n = GAP;
                    valid_n = 1'b0;
                    gap_n = '0;
                    idx_n = '0;
                end else if (!en) begin
                    state_n = IDLE;
                    valid_n = 1'b0;
                    idx_n = '0;
                end else idx_n = idx == IW'(BURST_LEN - 1) ? '0 : idx + 1'b1;
            end
            GAP: if (gap == GW'(GAP_LEN - 1)) begin
                state_n = en ? BURST : IDLE;
                valid_n = en;
            end else gap_n = gap + 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            gap <= '0;
            mode_q <= MODE_CNT;
            s.valid <= 1'b0;
            s.data <= '0;
            beat_cnt <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            gap <= gap_n;
            mode_q <= load ? mode : mode_q;
            s.valid <= valid_n;
            s.data <= !valid_n ? '0 : (load || acc) ? pat_nxt : pat_val;
            beat_cnt <= acc ? beat_cnt + 1'b1 : beat_cnt;
            busy <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_stream_src_gen.sv
// tb_stream_src_gen: randomized handshake bench against a beat-level reference model
module tb_stream_src_gen;
    localparam logic [31:0] SEED = 32'd1;
    localparam logic [31:0] TAPS = 32'h8020_0003;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, ready = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [31:0] cnt_a, cnt_b;
    logic busy_a, busy_b;
    bit sel;
    logic o_valid, o_busy;
    logic [31:0] o_data, o_cnt;
    int total, bad;
    string tname;
    bit mv, idle;
    int nb, gap_left, acc_cnt, bl, gl;
    logic [31:0] exp_val;
    logic [1:0] m_mode;

    stream_src_gen_if #(.DATA_W(32)) a_if ();
    stream_src_gen_if #(.DATA_W(32)) b_if ();
    assign a_if.ready = ready;
    assign b_if.ready = ready;

    stream_src_gen #(.BURST_LEN(4), .GAP_LEN(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(a_if), .beat_cnt(cnt_a), .busy(busy_a)
    );
    stream_src_gen #(.BURST_LEN(3), .GAP_LEN(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(b_if), .beat_cnt(cnt_b), .busy(busy_b)
    );

    assign o_valid = sel ? b_if.valid : a_if.valid;
    assign o_data = sel ? b_if.data : a_if.data;
    assign o_cnt = sel ? cnt_b : cnt_a;
    assign o_busy = sel ? busy_b : busy_a;

    always #5 clk = ~clk;

    function automatic logic [31:0] first_val(input logic [1:0] m);
        if (m == 2'd2) return 32'd1;
        if (m == 2'd1 && SEED == 32'd0) return 32'd1;
        return SEED;
    endfunction

    function automatic logic [31:0] pat_next(input logic [1:0] m, input logic [31:0] v);
        if (m == 2'd1) return (v % 2 == 1) ? (v / 2) ^ TAPS : v / 2;
        if (m == 2'd2) return v == 32'h8000_0000 ? 32'd1 : v * 2;
        return v + 32'd1;
    endfunction

    task automatic reset_model();
        idle = 1'b1;
        mv = 1'b0;
        nb = 0;
        gap_left = 0;
        acc_cnt = 0;
        exp_val = 32'd0;
    endtask

    task automatic do_reset(input bit which);
        sel = which;
        bl = which ? 3 : 4;
        gl = which ? 0 : 2;
        en = 1'b0;
        ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    // compare the visible beat against the model, then advance one clock
    task automatic step(input bit rdy);
        ready = rdy;
        total++;
        if (o_valid !== mv) begin bad++; $display("FAIL %s valid got %0b want %0b", tname, o_valid, mv); end
        total++;
        if (o_data !== (mv ? exp_val : 32'd0)) begin
            bad++; $display("FAIL %s data got %h want %h", tname, o_data, mv ? exp_val : 32'd0);
        end
        total++;
        if (o_cnt !== 32'(acc_cnt)) begin bad++; $display("FAIL %s beat_cnt got %0d want %0d", tname, o_cnt, acc_cnt); end
        total++;
        if (o_busy !== !idle) begin bad++; $display("FAIL %s busy got %0b want %0b", tname, o_busy, !idle); end
        if (mv && rdy) begin
            acc_cnt++;
            exp_val = pat_next(m_mode, exp_val);
            nb++;
            if (nb == bl) begin
                nb = 0;
                if (gl > 0) begin mv = 1'b0; gap_left = gl; end
                else if (!en) begin mv = 1'b0; idle = 1'b1; end
            end else if (!en) begin
                mv = 1'b0; idle = 1'b1; nb = 0;
            end
        end else if (!idle && !mv) begin
            gap_left--;
            if (gap_left == 0) begin
                if (en) mv = 1'b1;
                else idle = 1'b1;
            end
        end else if (idle && en) begin
            idle = 1'b0; mv = 1'b1; nb = 0; m_mode = mode; exp_val = first_val(mode);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tname = "reset";
        do_reset(1'b0);
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL reset valid got %0b want 0", o_valid); end
        total++;
        if (o_data !== 32'd0) begin bad++; $display("FAIL reset data got %h want 0", o_data); end
        total++;
        if (o_cnt !== 32'd0) begin bad++; $display("FAIL reset beat_cnt got %0d want 0", o_cnt); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL reset busy got %0b want 0", o_busy); end
        for (int i = 0; i < 3; i++) step(1'b1);
    endtask

    task automatic test_counter();
        tname = "counter";
        do_reset(1'b0);
        mode = 2'd0;
        en = 1'b1;
        for (int i = 0; i < 11; i++) step(1'b1);
        total++;
        if (o_cnt !== 32'd8) begin bad++; $display("FAIL counter_two_bursts beat_cnt got %0d want 8", o_cnt); end
        mode = 2'd3;
        for (int i = 0; i < 60; i++) step($urandom_range(0, 99) < 60);
    endtask

    task automatic test_backpressure();
        int hold;
        tname = "backpressure";
        do_reset(1'b0);
        mode = 2'd0;
        en = 1'b1;
        hold = 0;
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 4; i++) begin
            if (o_valid === 1'b1 && o_data === 32'd2) hold++;
            step(i == 3);
        end
        total++;
        if (hold !== 4) begin bad++; $display("FAIL backpressure_hold cycles got %0d want 4", hold); end
        for (int i = 0; i < 10; i++) step(1'b1);
    endtask

    task automatic test_lfsr();
        tname = "lfsr";
        do_reset(1'b0);
        mode = 2'd1;
        en = 1'b1;
        for (int c = 0; c < 5000 && acc_cnt < 1000; c++) step($urandom_range(0, 99) < 70);
        total++;
        if (acc_cnt < 1000) begin bad++; $display("FAIL lfsr_budget beats got %0d want 1000", acc_cnt); end
    endtask

    task automatic test_walk();
        tname = "walk";
        do_reset(1'b0);
        mode = 2'd2;
        en = 1'b1;
        for (int i = 0; i < 40; i++) step($urandom_range(0, 99) < 75);
        mode = 2'd0;
        for (int i = 0; i < 40; i++) step($urandom_range(0, 99) < 75);
    endtask

    task automatic test_back_to_back();
        tname = "back_to_back";
        do_reset(1'b1);
        mode = 2'd0;
        en = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1);
        for (int i = 0; i < 40; i++) step($urandom_range(0, 99) < 50);
        en = 1'b0;
        for (int i = 0; i < 8; i++) step($urandom_range(0, 99) < 50);
    endtask

    task automatic test_en_fall();
        tname = "en_fall";
        do_reset(1'b0);
        mode = 2'd0;
        en = 1'b1;
        step(1'b1);
        step(1'b1);
        en = 1'b0;
        step(1'b0);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        total++;
        if (o_cnt !== 32'd2) begin bad++; $display("FAIL en_fall beat_cnt got %0d want 2", o_cnt); end
        for (int i = 0; i < 4; i++) step(1'b1);
    endtask

    task automatic test_async_reset();
        tname = "async_reset";
        do_reset(1'b0);
        mode = 2'd0;
        en = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL async_reset valid got %0b want 0", o_valid); end
        total++;
        if (o_data !== 32'd0) begin bad++; $display("FAIL async_reset data got %h want 0", o_data); end
        total++;
        if (o_cnt !== 32'd0) begin bad++; $display("FAIL async_reset beat_cnt got %0d want 0", o_cnt); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("FAIL async_reset busy got %0b want 0", o_busy); end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 8; i++) step(1'b1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        m_mode = 2'd0;
        test_reset();
        test_counter();
        test_backpressure();
        test_lfsr();
        test_walk();
        test_back_to_back();
        test_en_fall();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
